// File: rtl/keyscan.sv
// 4x4 key-matrix scanner: drives one column low per slot, samples the synchronized
// rows, and commits a frame to keys once it has repeated for DEBOUNCE frames.
module keyscan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        key_event,
  output logic        frame_done
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  CNT_MAX  = 4'(DEBOUNCE - 1);

  logic [3:0]  row_m_q, row_m_d;
  logic [3:0]  row_s_q, row_s_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  col_out_q, col_out_d;
  logic [11:0] acc_q, acc_d;
  logic [15:0] prev_frame_q, prev_frame_d;
  logic [3:0]  stable_cnt_q, stable_cnt_d;
  logic [15:0] keys_q, keys_d;
  logic        key_event_q, key_event_d;
  logic        frame_done_q, frame_done_d;

  logic        sample;
  logic [15:0] new_frame;
  logic [3:0]  cnt_next;

  always_comb begin
    row_m_d      = row_in;
    row_s_d      = row_m_q;
    div_d        = div_q;
    col_d        = col_q;
    col_out_d    = col_out_q;
    acc_d        = acc_q;
    prev_frame_d = prev_frame_q;
    stable_cnt_d = stable_cnt_q;
    keys_d       = keys_q;
    key_event_d  = 1'b0;
    frame_done_d = 1'b0;

    sample    = (div_q == DIV_LAST);
    new_frame = {~row_s_q, acc_q};
    if (new_frame == prev_frame_q) begin
      cnt_next = (stable_cnt_q >= CNT_MAX) ? CNT_MAX : stable_cnt_q + 4'd1;
    end else begin
      cnt_next = 4'd0;
    end

    if (sample) begin
      div_d     = 16'd0;
      col_d     = col_q + 2'd1;
      col_out_d = ~(4'b0001 << col_d);
      case (col_q)
        2'd0: acc_d[3:0]  = ~row_s_q;
        2'd1: acc_d[7:4]  = ~row_s_q;
        2'd2: acc_d[11:8] = ~row_s_q;
        default: begin
          // Column 3 completes the frame; its nibble goes straight into new_frame.
          stable_cnt_d = cnt_next;
          prev_frame_d = new_frame;
          frame_done_d = 1'b1;
          if ((cnt_next == CNT_MAX) && (new_frame != keys_q)) begin
            keys_d      = new_frame;
            key_event_d = 1'b1;
          end
        end
      endcase
    end else begin
      div_d = div_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_m_q      <= 4'b1111;
      row_s_q      <= 4'b1111;
      div_q        <= 16'd0;
      col_q        <= 2'd0;
      col_out_q    <= 4'b1110;
      acc_q        <= 12'd0;
      prev_frame_q <= 16'd0;
      stable_cnt_q <= 4'd0;
      keys_q       <= 16'd0;
      key_event_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_m_q      <= row_m_d;
      row_s_q      <= row_s_d;
      div_q        <= div_d;
      col_q        <= col_d;
      col_out_q    <= col_out_d;
      acc_q        <= acc_d;
      prev_frame_q <= prev_frame_d;
      stable_cnt_q <= stable_cnt_d;
      keys_q       <= keys_d;
      key_event_q  <= key_event_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign col_out    = col_out_q;
  assign keys       = keys_q;
  assign key_event  = key_event_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keyscan.sv
// Bench for keyscan: a simulated key matrix plus a frame-history reference model,
// compared against the DUT every cycle, with a few hand-computed anchor checks.
module tb_keyscan;

  localparam int SD = 4;
  localparam int DB = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        key_event;
  logic        frame_done;
  logic [15:0] pressed = 16'h0000;

  int total = 0;
  int bad = 0;
  int fd_seen = 0;
  int ev_seen = 0;

  int          cyc;
  logic [15:0] hist[$];
  logic [15:0] frames[$];
  logic [15:0] acc_m;
  logic [15:0] keys_m;
  logic        ev_m;
  logic        fd_m;

  keyscan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .row_in     (row_in),
    .col_out    (col_out),
    .keys       (keys),
    .key_event  (key_event),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (!col_out[i]) row_in = row_in & ~pressed[i*4 +: 4];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    hist.delete();
    frames.delete();
    frames.push_back(16'h0000);
    acc_m  = 16'h0000;
    keys_m = 16'h0000;
    ev_m   = 1'b0;
    fd_m   = 1'b0;
  endtask

  // One clock cycle: update the model from the key set seen two cycles before
  // each column's sample point, then compare every output.
  task automatic step();
    int          div;
    int          col;
    logic [15:0] seen;
    logic [3:0]  exp_col;
    bit          all_eq;
    hist.push_back(pressed);
    @(posedge clock);
    div  = cyc % SD;
    col  = (cyc / SD) % 4;
    ev_m = 1'b0;
    fd_m = 1'b0;
    if (div == SD - 1) begin
      seen = (cyc >= 2) ? hist[cyc-2] : 16'h0000;
      acc_m[col*4 +: 4] = seen[col*4 +: 4];
      if (col == 3) begin
        fd_m = 1'b1;
        frames.push_back(acc_m);
        all_eq = (frames.size() >= DB);
        if (all_eq) begin
          for (int k = 1; k < DB; k++) begin
            if (frames[frames.size()-1-k] != acc_m) all_eq = 0;
          end
        end
        if (all_eq && (acc_m != keys_m)) begin
          keys_m = acc_m;
          ev_m   = 1'b1;
        end
      end
    end
    cyc++;
    #1;
    exp_col = 4'b0001 << ((cyc / SD) % 4);
    exp_col = ~exp_col;
    chk("col_out", col_out, exp_col);
    chk("keys", keys, keys_m);
    chk("key_event", key_event, ev_m);
    chk("frame_done", frame_done, fd_m);
    if (frame_done) fd_seen++;
    if (key_event) ev_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_col_out"}, col_out, 4'b1110);
    chk({tag, "_keys"}, keys, 16'h0000);
    chk({tag, "_key_event"}, key_event, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    fd_seen = 0;
    ev_seen = 0;
  endtask

  initial begin
    logic [15:0] pool;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("init");
    reset_n = 1'b1;
    model_reset();

    // Idle scan: four frames, no key activity.
    run(64);
    chk("idle_frames", fd_seen, 4);
    chk("idle_events", ev_seen, 0);

    // Key 6 held from a frame boundary commits at the end of frame 3.
    do_reset();
    pressed = 16'h0040;
    run(47);
    chk("k6_before", keys, 16'h0000);
    run(1);
    chk("k6_commit", keys, 16'h0040);
    chk("k6_event", key_event, 1'b1);
    ev_seen = 0;
    run(160);
    chk("k6_hold_events", ev_seen, 0);

    // Bounce: alternating single frames never commit.
    do_reset();
    pressed = 16'h0040; run(16);
    pressed = 16'h0000; run(16);
    pressed = 16'h0040; run(16);
    pressed = 16'h0000; run(64);
    chk("bounce_keys", keys, 16'h0000);
    chk("bounce_events", ev_seen, 0);

    // Corner keys together, then released.
    do_reset();
    pressed = 16'h8001;
    run(48);
    chk("k0_15_press", keys, 16'h8001);
    chk("k0_15_press_ev", ev_seen, 1);
    pressed = 16'h0000;
    ev_seen = 0;
    run(47);
    chk("k0_15_hold_off", keys, 16'h8001);
    run(1);
    chk("k0_15_release", keys, 16'h0000);
    chk("k0_15_release_ev", ev_seen, 1);

    // Reset during column 2 of frame 3 with the key already stable once.
    do_reset();
    pressed = 16'h0040;
    run(41);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    run(47);
    chk("mid_before", keys, 16'h0000);
    run(1);
    chk("mid_commit", keys, 16'h0040);

    // Randomized key activity with occasional resets.
    do_reset();
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 4))
        0: pool = 16'h0000;
        1: pool = 16'h0040;
        2: pool = 16'h8001;
        3: pool = 16'h0001 << $urandom_range(0, 15);
        default: pool = 16'($urandom);
      endcase
      pressed = pool;
      run($urandom_range(1, 60));
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
